// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: two writeback requesters (ALU, memory load),
// each with a one-entry holding buffer, round-robin arbitration between full
// buffers, and a registered register-file write port. Writes to register 0
// are dropped and counted in a saturating counter.
module rf_write_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         req0_valid_i,
  input  logic [4:0]   req0_addr_i,
  input  logic [N-1:0] req0_data_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [4:0]   req1_addr_i,
  input  logic [N-1:0] req1_data_i,
  output logic         req1_ready_o,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  output logic [1:0]   grant_o,
  output logic [7:0]   zero_drop_cnt_o,
  output logic         busy_o
);

  // Holding buffers
  logic         full0_q, full0_d;
  logic [4:0]   addr0_q, addr0_d;
  logic [N-1:0] data0_q, data0_d;
  logic         full1_q, full1_d;
  logic [4:0]   addr1_q, addr1_d;
  logic [N-1:0] data1_q, data1_d;

  // Round-robin pointer: 1 means requester 1 was granted most recently
  logic         rr_q, rr_d;

  // Registered output stage
  logic         reg_write_q, reg_write_d;
  logic [4:0]   wr_addr_q, wr_addr_d;
  logic [N-1:0] wr_data_q, wr_data_d;
  logic [1:0]   grant_q, grant_d;
  logic [7:0]   zero_cnt_q, zero_cnt_d;

  // Combinational arbitration and handshake
  logic         gnt0_s, gnt1_s;
  logic         ready0_s, ready1_s;
  logic         acc0_s, acc1_s;
  logic [4:0]   sel_addr_s;
  logic [N-1:0] sel_data_s;

  // Grant the lone full buffer, or on a tie the requester not granted last
  always_comb begin
    gnt0_s = full0_q & (~full1_q | rr_q);
    gnt1_s = full1_q & (~full0_q | ~rr_q);
  end

  // Ready when the buffer is free or drains this cycle; never during flush or reset
  always_comb begin
    ready0_s = ~reset & ~flush_i & (~full0_q | gnt0_s);
    ready1_s = ~reset & ~flush_i & (~full1_q | gnt1_s);
    acc0_s   = req0_valid_i & ready0_s;
    acc1_s   = req1_valid_i & ready1_s;
  end

  // Mux the granted buffer toward the output stage
  always_comb begin
    if (gnt1_s) begin
      sel_addr_s = addr1_q;
      sel_data_s = data1_q;
    end else begin
      sel_addr_s = addr0_q;
      sel_data_s = data0_q;
    end
  end

  // Holding-buffer next state: refill on accept, drain on grant, clear on flush
  always_comb begin
    full0_d = full0_q;
    addr0_d = addr0_q;
    data0_d = data0_q;
    full1_d = full1_q;
    addr1_d = addr1_q;
    data1_d = data1_q;
    if (flush_i) begin
      full0_d = 1'b0;
      full1_d = 1'b0;
    end else begin
      if (acc0_s) begin
        full0_d = 1'b1;
        addr0_d = req0_addr_i;
        data0_d = req0_data_i;
      end else if (gnt0_s) begin
        full0_d = 1'b0;
      end else begin
        full0_d = full0_q;
      end
      if (acc1_s) begin
        full1_d = 1'b1;
        addr1_d = req1_addr_i;
        data1_d = req1_data_i;
      end else if (gnt1_s) begin
        full1_d = 1'b0;
      end else begin
        full1_d = full1_q;
      end
    end
  end

  // Output stage and pointer next state; a flush suppresses the pending grant entirely
  always_comb begin
    rr_d        = rr_q;
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    grant_d     = 2'b00;
    zero_cnt_d  = zero_cnt_q;
    if (~flush_i && (gnt0_s || gnt1_s)) begin
      rr_d      = gnt1_s;
      wr_addr_d = sel_addr_s;
      wr_data_d = sel_data_s;
      grant_d   = {gnt1_s, gnt0_s};
      if (sel_addr_s != 5'd0) begin
        reg_write_d = 1'b1;
      end else if (zero_cnt_q != 8'hFF) begin
        zero_cnt_d = zero_cnt_q + 8'd1;
      end else begin
        zero_cnt_d = zero_cnt_q;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // State registers with synchronous reset; pointer resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      full0_q     <= 1'b0;
      addr0_q     <= 5'd0;
      data0_q     <= '0;
      full1_q     <= 1'b0;
      addr1_q     <= 5'd0;
      data1_q     <= '0;
      rr_q        <= 1'b1;
      reg_write_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= '0;
      grant_q     <= 2'b00;
      zero_cnt_q  <= 8'd0;
    end else begin
      full0_q     <= full0_d;
      addr0_q     <= addr0_d;
      data0_q     <= data0_d;
      full1_q     <= full1_d;
      addr1_q     <= addr1_d;
      data1_q     <= data1_d;
      rr_q        <= rr_d;
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      grant_q     <= grant_d;
      zero_cnt_q  <= zero_cnt_d;
    end
  end

  // Output drive; busy is derived purely from flops
  always_comb begin
    req0_ready_o     = ready0_s;
    req1_ready_o     = ready1_s;
    Reg_Write_o      = reg_write_q;
    Write_Register_o = wr_addr_q;
    Write_Data_o     = wr_data_q;
    grant_o          = grant_q;
    zero_drop_cnt_o  = zero_cnt_q;
    busy_o           = full0_q | full1_q | (grant_q != 2'b00);
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed table-driven bench for rf_write_arbiter plus hand-written
// sequences for reset, counter saturation and mid-stream reset.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        flush_i;
  logic        req0_valid_i;
  logic [4:0]  req0_addr_i;
  logic [31:0] req0_data_i;
  logic        req0_ready_o;
  logic        req1_valid_i;
  logic [4:0]  req1_addr_i;
  logic [31:0] req1_data_i;
  logic        req1_ready_o;
  logic        Reg_Write_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;
  logic [1:0]  grant_o;
  logic [7:0]  zero_drop_cnt_o;
  logic        busy_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  rf_write_arbiter #(.N(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_i          (flush_i),
    .req0_valid_i     (req0_valid_i),
    .req0_addr_i      (req0_addr_i),
    .req0_data_i      (req0_data_i),
    .req0_ready_o     (req0_ready_o),
    .req1_valid_i     (req1_valid_i),
    .req1_addr_i      (req1_addr_i),
    .req1_data_i      (req1_data_i),
    .req1_ready_o     (req1_ready_o),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o),
    .grant_o          (grant_o),
    .zero_drop_cnt_o  (zero_drop_cnt_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  g;
    logic [7:0]  z;
    logic        busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic fl, logic v0, logic [4:0] a0, logic [31:0] d0,
                              logic v1, logic [4:0] a1, logic [31:0] d1,
                              logic r0, logic r1, logic rw, logic [4:0] wreg,
                              logic [31:0] wdata, logic [1:0] g, logic [7:0] z, logic busy);
    vec_t v;
    v.flush = fl; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.rw = rw; v.wreg = wreg; v.wdata = wdata; v.g = g; v.z = z;
    v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    flush_i = fl;
    req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
    req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
  endtask

  function automatic logic [63:0] outs();
    return {15'd0, Reg_Write_o, Write_Register_o, Write_Data_o, grant_o, zero_drop_cnt_o, busy_o};
  endfunction

  initial begin
    logic [63:0] exp_o;
    logic        saw_rw;

    // Idle after the first tie: A/B/C/E/F data tags are arbitrary distinct values
    // Tie after reset: req0 first, then req1; register 3 finishes at 0x22
    vt.push_back(mk(0,1,3,32'h11,1,3,32'h22, 1,1, 0,0,32'h0,2'b00,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,0, 1,3,32'h11,2'b01,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 1,3,32'h22,2'b10,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,3,32'h22,2'b00,0,0));
    // Single write
    vt.push_back(mk(0,1,5,32'hDEADBEEF,0,0,32'h0, 1,1, 0,3,32'h22,2'b00,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 1,5,32'hDEADBEEF,2'b01,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,5,32'hDEADBEEF,2'b00,0,0));
    // Sustained contention, requester holds its offer until accepted
    vt.push_back(mk(0,1,1,32'hA0,1,2,32'hB0, 1,1, 0,5,32'hDEADBEEF,2'b00,0,1));
    vt.push_back(mk(0,1,1,32'hA1,1,2,32'hB1, 0,1, 1,2,32'hB0,2'b10,0,1));
    vt.push_back(mk(0,1,1,32'hA1,1,2,32'hB2, 1,0, 1,1,32'hA0,2'b01,0,1));
    vt.push_back(mk(0,1,1,32'hA2,1,2,32'hB2, 0,1, 1,2,32'hB1,2'b10,0,1));
    vt.push_back(mk(0,1,1,32'hA2,1,2,32'hB3, 1,0, 1,1,32'hA1,2'b01,0,1));
    vt.push_back(mk(0,1,1,32'hA3,1,2,32'hB3, 0,1, 1,2,32'hB2,2'b10,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,0, 1,1,32'hA2,2'b01,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 1,2,32'hB3,2'b10,0,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,2,32'hB3,2'b00,0,0));
    // Zero-address writes from requester 1
    vt.push_back(mk(0,0,0,32'h0,1,0,32'hC1,  1,1, 0,2,32'hB3,2'b00,0,1));
    vt.push_back(mk(0,0,0,32'h0,1,0,32'hC2,  1,1, 0,0,32'hC1,2'b10,1,1));
    vt.push_back(mk(0,0,0,32'h0,1,0,32'hC3,  1,1, 0,0,32'hC2,2'b10,2,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,0,32'hC3,2'b10,3,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,0,32'hC3,2'b00,3,0));
    // Flush with both buffers full; pointer must survive the flush
    vt.push_back(mk(0,1,7,32'hE0,1,8,32'hE1, 1,1, 0,0,32'hC3,2'b00,3,1));
    vt.push_back(mk(1,1,9,32'hE2,1,10,32'hE3,0,0, 0,0,32'hC3,2'b00,3,0));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,0,32'hC3,2'b00,3,0));
    vt.push_back(mk(0,1,4,32'hF0,1,4,32'hF1, 1,1, 0,0,32'hC3,2'b00,3,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,0, 1,4,32'hF0,2'b01,3,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 1,4,32'hF1,2'b10,3,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 0,4,32'hF1,2'b00,3,0));
    // A registered write completes even though flush follows it
    vt.push_back(mk(0,1,6,32'h66,0,0,32'h0,  1,1, 0,4,32'hF1,2'b00,3,1));
    vt.push_back(mk(0,0,0,32'h0,0,0,32'h0,   1,1, 1,6,32'h66,2'b01,3,1));
    vt.push_back(mk(1,0,0,32'h0,0,0,32'h0,   0,0, 0,6,32'h66,2'b00,3,0));

    // Reset with requests offered: no ready, no accept, outputs at reset values
    reset = 1'b1;
    drive(1'b0, 1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h66);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {62'd0, req0_ready_o, req1_ready_o}, 64'd0);
    chk("reset_outs", outs(), 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_no_accept", outs(), 64'd0);

    // Table-driven vectors
    foreach (vt[i]) begin
      drive(vt[i].flush, vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1);
      #1;
      chk($sformatf("vec%0d_ready", i), {62'd0, req0_ready_o, req1_ready_o},
          {62'd0, vt[i].r0, vt[i].r1});
      @(posedge clk);
      #1;
      exp_o = {15'd0, vt[i].rw, vt[i].wreg, vt[i].wdata, vt[i].g, vt[i].z, vt[i].busy};
      chk($sformatf("vec%0d_outs", i), outs(), exp_o);
    end

    // Counter saturation: 300 back-to-back zero-address writes on top of 3
    saw_rw = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5A);
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk);
      #1;
      if (Reg_Write_o) saw_rw = 1'b1;
      if (j == 252) chk("zcnt_254", {56'd0, zero_drop_cnt_o}, 64'd254);
      if (j == 253) chk("zcnt_255", {56'd0, zero_drop_cnt_o}, 64'd255);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("zcnt_sat", {56'd0, zero_drop_cnt_o}, 64'd255);
    chk("zero_no_write", {63'd0, saw_rw}, 64'd0);

    // Reset mid-stream with both buffers full
    drive(1'b0, 1'b1, 5'd1, 32'h77, 1'b1, 5'd2, 32'h88);
    @(posedge clk);
    #1;
    chk("mid_fill_busy", {63'd0, busy_o}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_ready", {62'd0, req0_ready_o, req1_ready_o}, 64'd0);
    @(posedge clk);
    #1;
    chk("mid_reset_outs", outs(), 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_idle%0d", k), outs(), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
